// File: rtl/tex_tag_lookup_if.sv
// tex_tag_lookup_if: request, result, L2 fetch, invalidation and statistics signals of the tag lookup
interface tex_tag_lookup_if #(
  parameter int ADDR_W     = 48,
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 256
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [3:0]        in_mip;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_idx;
  logic [OFF_W-1:0]  out_off;
  logic [3:0]        out_mip;
  logic              out_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic              inv_valid;
  logic [ADDR_W-1:0] inv_addr;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;
  logic [31:0]       inv_cnt;
  modport slave (
    input  in_valid, in_addr, in_mip, out_ready, mem_req_ready, mem_rsp_valid, inv_valid, inv_addr,
    output in_ready, out_valid, out_idx, out_off, out_mip, out_hit, mem_req_valid, mem_req_addr,
           hit_cnt, miss_cnt, inv_cnt
  );
  modport master (
    output in_valid, in_addr, in_mip, out_ready, mem_req_ready, mem_rsp_valid, inv_valid, inv_addr,
    input  in_ready, out_valid, out_idx, out_off, out_mip, out_hit, mem_req_valid, mem_req_addr,
           hit_cnt, miss_cnt, inv_cnt
  );
endinterface

// File: rtl/tex_tag_lookup.sv
// tex_tag_lookup: direct-mapped texture tag lookup with single outstanding L2 fill and write-notify invalidation
module tex_tag_lookup #(
  parameter int ADDR_W     = 48,
  parameter int LINE_BYTES = 64,
  parameter int NUM_LINES  = 256
) (
  input logic              clk,
  input logic              rst_n,
  tex_tag_lookup_if.slave  bus
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, REQ, WAIT, EMIT} state_t;
  state_t state, state_nx;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [ADDR_W-1:0]    req_addr;
  logic [3:0]           req_mip;
  logic                 rdy_en, hit_r, stale;
  logic [31:0]          hit_q, miss_q, inv_q;
  logic [TAG_W-1:0]     req_tag, inv_tag;
  logic [IDX_W-1:0]     req_idx, inv_idx;
  logic                 in_ready, accept, inv_hit, inv_req, in_flight, stale_now, lookup_hit, fill;
  logic                 unused_inv_off;
  assign req_tag    = req_addr[ADDR_W-1:OFF_W+IDX_W];
  assign req_idx    = req_addr[OFF_W+IDX_W-1:OFF_W];
  assign inv_tag    = bus.inv_addr[ADDR_W-1:OFF_W+IDX_W];
  assign inv_idx    = bus.inv_addr[OFF_W+IDX_W-1:OFF_W];
  assign unused_inv_off = ^bus.inv_addr[OFF_W-1:0];
  assign in_ready   = rdy_en & (state == IDLE);
  assign accept     = bus.in_valid & in_ready;
  assign inv_hit    = bus.inv_valid & valid[inv_idx] & (tags[inv_idx] == inv_tag);
  assign inv_req    = bus.inv_valid & (bus.inv_addr[ADDR_W-1:OFF_W] == req_addr[ADDR_W-1:OFF_W]);
  assign in_flight  = (state == REQ) | (state == WAIT);
  // an invalidation racing the fill must not leave the fetched line marked valid
  assign stale_now  = stale | (inv_req & in_flight);
  assign lookup_hit = valid[req_idx] & (tags[req_idx] == req_tag) & ~(inv_hit & (inv_idx == req_idx));
  assign fill       = (state == WAIT) & bus.mem_rsp_valid;
  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = state == EMIT;
  assign bus.mem_req_valid = state == REQ;
  assign bus.out_idx       = req_idx;
  assign bus.out_off       = req_addr[OFF_W-1:0];
  assign bus.out_mip       = req_mip;
  assign bus.out_hit       = hit_r;
  assign bus.mem_req_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
  assign bus.hit_cnt       = hit_q;
  assign bus.miss_cnt      = miss_q;
  assign bus.inv_cnt       = inv_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? LOOKUP : IDLE;
      LOOKUP:  state_nx = lookup_hit ? EMIT : REQ;
      REQ:     state_nx = bus.mem_req_ready ? WAIT : REQ;
      WAIT:    state_nx = bus.mem_rsp_valid ? EMIT : WAIT;
      EMIT:    state_nx = bus.out_ready ? IDLE : EMIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy_en   <= 1'b0;
      req_addr <= '0;
      req_mip  <= '0;
      hit_r    <= 1'b0;
      stale    <= 1'b0;
      valid    <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      inv_q    <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) begin
        req_addr <= bus.in_addr;
        req_mip  <= bus.in_mip;
      end
      if (state == LOOKUP) hit_r <= lookup_hit;
      stale <= (state == LOOKUP) ? 1'b0 : stale_now;
      if (inv_hit) valid[inv_idx] <= 1'b0;
      if (fill) valid[req_idx] <= ~stale_now;
      if (state == LOOKUP && lookup_hit && hit_q != '1) hit_q <= hit_q + 32'd1;
      if (state == LOOKUP && !lookup_hit && miss_q != '1) miss_q <= miss_q + 32'd1;
      if (inv_hit && inv_q != '1) inv_q <= inv_q + 32'd1;
    end
  always_ff @(posedge clk)
    if (fill) tags[req_idx] <= req_tag;
endmodule

// File: tb/tb_tex_tag_lookup.sv
// tb_tex_tag_lookup: directed checks of hit/miss, conflicts, invalidation, stalls and mid-miss reset
module tb_tex_tag_lookup;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  tex_tag_lookup_if #(.ADDR_W(48), .LINE_BYTES(64), .NUM_LINES(256)) bus ();
  tex_tag_lookup #(.ADDR_W(48), .LINE_BYTES(64), .NUM_LINES(256)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask
  task automatic lookup(input string t, input logic [47:0] a, input logic [3:0] m, input logic eh,
                        input logic [7:0] ei, input logic [5:0] eo,
                        input logic iw, input logic [47:0] iwa,
                        input logic ifl, input logic [47:0] ifa, input int stall);
    int n;
    bus.in_addr = a;
    bus.in_mip = m;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick; n++; end
    chk({t, " in_ready"}, bus.in_ready, 1);
    tick;
    bus.in_valid = 1'b0;
    chk({t, " out_valid N+1"}, bus.out_valid, 0);
    tick;
    chk({t, " out_valid N+2"}, bus.out_valid, eh);
    if (!eh) begin
      chk({t, " mem_req_valid"}, bus.mem_req_valid, 1);
      chk({t, " mem_req_addr"}, bus.mem_req_addr, {a[47:6], 6'b0});
      tick;
      chk({t, " mem_req_addr held"}, bus.mem_req_addr, {a[47:6], 6'b0});
      bus.mem_req_ready = 1'b1;
      tick;
      bus.mem_req_ready = 1'b0;
      chk({t, " mem_req_valid drop"}, bus.mem_req_valid, 0);
      bus.inv_valid = iw;
      bus.inv_addr = iwa;
      tick;
      bus.inv_valid = ifl;
      bus.inv_addr = ifa;
      bus.mem_rsp_valid = 1'b1;
      tick;
      bus.mem_rsp_valid = 1'b0;
      bus.inv_valid = 1'b0;
    end
    n = 0;
    while (!bus.out_valid && n < 20) begin tick; n++; end
    chk({t, " out_valid"}, bus.out_valid, 1);
    chk({t, " out_hit"}, bus.out_hit, eh);
    chk({t, " out_idx"}, bus.out_idx, ei);
    chk({t, " out_off"}, bus.out_off, eo);
    chk({t, " out_mip"}, bus.out_mip, m);
    for (int i = 0; i < stall; i++) begin
      tick;
      chk({t, " stall out_valid"}, bus.out_valid, 1);
      chk({t, " stall in_ready"}, bus.in_ready, 0);
      chk({t, " stall out_idx"}, bus.out_idx, ei);
      chk({t, " stall out_off"}, bus.out_off, eo);
    end
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk({t, " out_valid after"}, bus.out_valid, 0);
    chk({t, " in_ready after"}, bus.in_ready, 1);
  endtask
  task automatic inv(input logic [47:0] a);
    bus.inv_addr = a;
    bus.inv_valid = 1'b1;
    tick;
    bus.inv_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid = 0; bus.in_addr = '0; bus.in_mip = '0; bus.out_ready = 0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.inv_valid = 0; bus.inv_addr = '0;
    repeat (2) tick;
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst mem_req_valid", bus.mem_req_valid, 0);
    chk("rst hit_cnt", bus.hit_cnt, 0);
    rst_n = 1'b1;
    #1;
    chk("release in_ready before edge", bus.in_ready, 0);
    tick;
    chk("release in_ready", bus.in_ready, 1);
    lookup("cold", 48'h1040, 4'd3, 0, 8'h41, 6'h00, 0, '0, 0, '0, 0);
    chk("cold miss_cnt", bus.miss_cnt, 1);
    lookup("repeat", 48'h1048, 4'd5, 1, 8'h41, 6'h08, 0, '0, 0, '0, 0);
    chk("repeat hit_cnt", bus.hit_cnt, 1);
    lookup("conflict", 48'h5040, 4'd1, 0, 8'h41, 6'h00, 0, '0, 0, '0, 0);
    lookup("refetch", 48'h1040, 4'd2, 0, 8'h41, 6'h00, 0, '0, 0, '0, 0);
    chk("conflict miss_cnt", bus.miss_cnt, 3);
    inv(48'h1050);
    chk("inv match inv_cnt", bus.inv_cnt, 1);
    lookup("after inv", 48'h1040, 4'd0, 0, 8'h41, 6'h00, 0, '0, 0, '0, 0);
    chk("after inv miss_cnt", bus.miss_cnt, 4);
    inv(48'h9040);
    chk("inv nomatch inv_cnt", bus.inv_cnt, 1);
    lookup("after nomatch inv", 48'h1048, 4'd7, 1, 8'h41, 6'h08, 0, '0, 0, '0, 0);
    chk("after nomatch hit_cnt", bus.hit_cnt, 2);
    lookup("stale", 48'h2000, 4'd4, 0, 8'h80, 6'h00, 1, 48'h2000, 0, '0, 0);
    chk("stale inv_cnt", bus.inv_cnt, 1);
    lookup("stale refetch", 48'h2004, 4'd9, 0, 8'h80, 6'h04, 0, '0, 1, 48'h1040, 5);
    chk("stale refetch miss_cnt", bus.miss_cnt, 6);
    chk("fill+inv inv_cnt", bus.inv_cnt, 2);
    lookup("filled line", 48'h2000, 4'd4, 1, 8'h80, 6'h00, 0, '0, 0, '0, 0);
    lookup("inv on fill", 48'h1040, 4'd1, 0, 8'h41, 6'h00, 0, '0, 0, '0, 0);
    chk("pre-reset hit_cnt", bus.hit_cnt, 3);
    chk("pre-reset miss_cnt", bus.miss_cnt, 7);
    bus.in_addr = 48'h3000;
    bus.in_valid = 1'b1;
    tick;
    bus.in_valid = 1'b0;
    tick;
    chk("midmiss mem_req_addr", bus.mem_req_addr, 48'h3000);
    bus.mem_req_ready = 1'b1;
    tick;
    bus.mem_req_ready = 1'b0;
    chk("midmiss miss_cnt", bus.miss_cnt, 8);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst in_ready", bus.in_ready, 0);
    chk("async rst out_valid", bus.out_valid, 0);
    chk("async rst mem_req_valid", bus.mem_req_valid, 0);
    chk("async rst mem_req_addr", bus.mem_req_addr, 0);
    chk("async rst out_idx", bus.out_idx, 0);
    chk("async rst out_hit", bus.out_hit, 0);
    chk("async rst miss_cnt", bus.miss_cnt, 0);
    chk("async rst inv_cnt", bus.inv_cnt, 0);
    tick;
    rst_n = 1'b1;
    tick;
    bus.mem_rsp_valid = 1'b1;
    tick;
    bus.mem_rsp_valid = 1'b0;
    tick;
    chk("late rsp out_valid", bus.out_valid, 0);
    chk("late rsp in_ready", bus.in_ready, 1);
    lookup("post reset", 48'h1040, 4'd6, 0, 8'h41, 6'h00, 0, '0, 0, '0, 0);
    chk("post reset miss_cnt", bus.miss_cnt, 1);
    chk("post reset hit_cnt", bus.hit_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tex_tag_lookup.md
TEX_TAG_LOOKUP -- requirements
Module: tex_tag_lookup

Interface
REQ-001 SHALL have parameter ADDR_W, default 48: byte address width.
REQ-002 SHALL have parameter LINE_BYTES, default 64: line size, power of two.
REQ-003 SHALL have parameter NUM_LINES, default 256: direct-mapped lines, power of two.
REQ-004 SHALL define OFF_W=log2(LINE_BYTES), IDX_W=log2(NUM_LINES) and TAG_W=ADDR_W-OFF_W-IDX_W as localparams.
REQ-005 SHALL have the following ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  address request from the address-calculation stage.
- in_ready  out  1  request accepted.
- in_addr  in  ADDR_W  block-aligned texture byte address.
- in_mip  in  4  mip level, passed through.
- out_valid  out  1  lookup result valid.
- out_ready  in  1  result consumed.
- out_idx  out  IDX_W  cache line index.
- out_off  out  OFF_W  byte offset within line.
- out_mip  out  4  mip passthrough.
- out_hit  out  1  1 = hit, 0 = serviced by fill.
- mem_req_valid  out  1  line fetch request to L2.
- mem_req_ready  in  1  L2 accepted request.
- mem_req_addr  out  ADDR_W  line-aligned fetch address (low OFF_W bits 0).
- mem_rsp_valid  in  1  one-cycle pulse: fill for the outstanding request complete.
- inv_valid  in  1  write-notify invalidation.
- inv_addr  in  ADDR_W  written byte address.
- hit_cnt, miss_cnt, inv_cnt  out  32 each  saturating statistics.

Function
REQ-006 SHALL decompose addresses as off=addr[OFF_W-1:0], idx=addr[OFF_W+IDX_W-1:OFF_W], tag=addr[ADDR_W-1:OFF_W+IDX_W].
REQ-007 SHALL hold per-line tag[TAG_W] and valid[1] in flops.
REQ-008 SHALL implement FSM states IDLE, LOOKUP, REQ, WAIT, EMIT.
REQ-009 SHALL drive in_ready=1 only in IDLE; the handshake in_valid&in_ready SHALL capture addr/mip and go to LOOKUP.
REQ-010 In LOOKUP, hit SHALL be valid[idx] & (tag[idx]==req tag) & ~(same-cycle invalidation matching that line).
- hit: EMIT, out_hit=1, hit_cnt+1.
- miss: REQ, miss_cnt+1.
REQ-011 In REQ, mem_req_valid SHALL be 1 with mem_req_addr={tag,idx,0} held stable until mem_req_ready, then go to WAIT.
REQ-012 In WAIT, on mem_rsp_valid the FSM SHALL write tag[idx]=req tag and valid[idx]=~stale, then go to EMIT with out_hit=0; mem_rsp_valid outside WAIT SHALL be ignored.
REQ-013 In EMIT, out_valid SHALL be 1 with outputs stable until out_ready; on the handshake the FSM SHALL return to IDLE.
- Hit latency: accept at cycle N, out_valid at N+2.
- Only one request outstanding.
REQ-014 Invalidation SHALL be accepted every cycle in any state: if valid[inv idx] and tag matches, clear valid next edge and inv_cnt+1; non-matching invalidations SHALL have no effect.
REQ-015 An invalidation matching the outstanding line while in REQ/WAIT, or on the mem_rsp_valid cycle, SHALL set stale; the fill is then installed with valid=0 and the result still emitted once with out_hit=0.
REQ-016 On a fill and an invalidation to a different line in the same cycle, both SHALL take effect.
REQ-017 Counters SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-018 rst_n low SHALL asynchronously force:
- state IDLE;
- all valid bits 0, stale 0;
- out_valid, mem_req_valid, out_hit, out_idx, out_off, out_mip, mem_req_addr 0;
- all counters 0.
REQ-019 in_ready SHALL be 0 while rst_n is low and 1 from the first clock edge after release.
REQ-020 Reset mid-miss SHALL abandon the request; a later mem_rsp_valid SHALL be ignored.
REQ-021 Tag contents need not be reset.

Verification (ADDR_W=48, LINE_BYTES=64, NUM_LINES=256)
REQ-022 Cold miss: in_addr=0x1040 -> mem_req_addr=0x1040, idx=0x41; after mem_rsp_valid: out_valid, out_hit=0, out_idx=0x41, miss_cnt=1.
REQ-023 Repeat 0x1048 -> out_valid 2 cycles after accept, out_hit=1, out_off=0x08, hit_cnt=1.
REQ-024 Conflict: 0x5040 (same idx 0x41, tag 1) -> miss; a following 0x1040 -> miss; miss_cnt=3.
REQ-025 inv_addr=0x1050 after line 0x1040 is installed -> valid cleared, inv_cnt+1; next 0x1040 -> miss. inv_addr=0x9040 -> no effect.
REQ-026 inv_addr=0x2000 during WAIT for 0x2000 -> emitted out_hit=0; next 0x2000 -> miss again.
REQ-027 out_ready held 0 for 5 cycles -> outputs stable, in_ready=0; rst_n pulsed low in WAIT -> all outputs 0 immediately, late mem_rsp_valid ignored.
